// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display definitions: screen geometry, blitter state encoding
// and VRAM address helpers used by the blitter and video_multiplexer.
package chip8_pkg;

    localparam int SCREEN_W      = 64;
    localparam int SCREEN_H      = 32;
    localparam int BYTES_PER_ROW = 8;
    localparam int VRAM_BYTES    = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLS,
        ST_FETCH,
        ST_RD_A,
        ST_WR_A,
        ST_RD_B,
        ST_WR_B,
        ST_NEXT,
        ST_DONE
    } blit_state_e;

    // Byte address of one 8-pixel group: row-major, eight bytes per row.
    function automatic logic [15:0] vram_addr(input logic [4:0] y, input logic [2:0] xbyte);
        return {8'h00, y, xbyte};
    endfunction

    // Sprite bytes hold the leftmost pixel in bit 7; VRAM holds it in bit 0.
    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k] = b[7-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/latency_wait.sv
// Down-counter that is loaded when a read address is first presented and
// flags expiry once the read data is valid. Shared by sprite and VRAM reads.
module latency_wait #(
    parameter int LATENCY = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load_in,
    output logic expired_out
);

    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    logic [CW-1:0] cnt_q;

    // Load on entry to a wait state, then count down to zero and hold there.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (load_in) begin
            cnt_q <= CW'(LATENCY);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_out = (cnt_q == '0);

endmodule

// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 DXYN / 00E0 engine: fetches sprite rows, XORs them into the
// 64x32 VRAM via read-modify-write, and reports busy/done/collision.
module chip8_sprite_blitter
    import chip8_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int WRAP_SPRITES = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        draw_start_in,
    input  logic        cls_start_in,
    input  logic [6:0]  x_in,
    input  logic [5:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_in,
    output logic [11:0] spr_addr_out,
    input  logic [7:0]  spr_data_in,
    output logic [15:0] vram_addr_out,
    output logic [7:0]  vram_wdata_out,
    output logic        vram_we_out,
    input  logic [7:0]  vram_rdata_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        collision_out
);

    blit_state_e state_q, state_d;

    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [3:0]  n_q;
    logic [11:0] i_q;
    logic [3:0]  row_q;
    logic [15:0] mask_q;
    logic [7:0]  rdata_q;
    logic        coll_q;
    logic [7:0]  cls_cnt_q;

    logic        lw_load;
    logic        lw_exp;
    logic        accept;
    logic [2:0]  xb_a;
    logic [2:0]  xb_b;
    logic        b_ok;
    logic [4:0]  vrow;
    logic [4:0]  row_inc;
    logic        clip;
    logic [15:0] fetch_mask;

    latency_wait #(
        .LATENCY (READ_LATENCY)
    ) u_wait (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (lw_load),
        .expired_out (lw_exp)
    );

    assign accept     = (state_q == ST_IDLE) && (draw_start_in || cls_start_in);
    assign xb_a       = x_q[5:3];
    assign xb_b       = x_q[5:3] + 3'd1;   // wraps 7 -> 0, used only when b_ok
    assign b_ok       = (xb_a != 3'(BYTES_PER_ROW - 1)) || (WRAP_SPRITES != 0);
    assign vrow       = y_q + 5'(row_q);  // modulo-32 row
    assign row_inc    = 5'(row_q) + 5'd1;
    assign clip       = ({1'b0, y_q} + 6'(row_inc)) >= 6'(SCREEN_H);
    assign fetch_mask = {8'h00, bit_reverse(spr_data_in)} << x_q[2:0];

    // State register and datapath registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            row_q     <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
            coll_q    <= 1'b0;
            cls_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q       <= 6'(32'(x_in) % SCREEN_W);
                y_q       <= 5'(32'(y_in) % SCREEN_H);
                n_q       <= n_in;
                i_q       <= i_in;
                row_q     <= '0;
                coll_q    <= 1'b0;
                cls_cnt_q <= '0;
            end
            if (state_q == ST_CLS) begin
                cls_cnt_q <= cls_cnt_q + 8'd1;
            end
            if (state_q == ST_FETCH && lw_exp) begin
                mask_q <= fetch_mask;
            end
            if ((state_q == ST_RD_A || state_q == ST_RD_B) && lw_exp) begin
                rdata_q <= vram_rdata_in;
            end
            if (state_q == ST_WR_A) begin
                coll_q <= coll_q | (|(rdata_q & mask_q[7:0]));
            end
            if (state_q == ST_WR_B) begin
                coll_q <= coll_q | (|(rdata_q & mask_q[15:8]));
            end
            if (state_q == ST_NEXT) begin
                row_q <= row_q + 4'd1;
            end
        end
    end

    // Next-state logic; empty mask bytes skip their read and write entirely.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        lw_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cls_start_in) begin
                    state_d = ST_CLS;
                end else if (draw_start_in) begin
                    if (n_in == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                        lw_load = 1'b1;
                    end
                end
            end
            ST_CLS: begin
                if (cls_cnt_q == 8'(VRAM_BYTES - 1)) state_d = ST_DONE;
            end
            ST_FETCH: begin
                if (lw_exp) begin
                    if (fetch_mask[7:0] != 8'h00) begin
                        state_d = ST_RD_A;
                        lw_load = 1'b1;
                    end else if (fetch_mask[15:8] != 8'h00 && b_ok) begin
                        state_d = ST_RD_B;
                        lw_load = 1'b1;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_RD_A: begin
                if (lw_exp) state_d = ST_WR_A;
            end
            ST_WR_A: begin
                if (mask_q[15:8] != 8'h00 && b_ok) begin
                    state_d = ST_RD_B;
                    lw_load = 1'b1;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_RD_B: begin
                if (lw_exp) state_d = ST_WR_B;
            end
            ST_WR_B: state_d = ST_NEXT;
            ST_NEXT: begin
                if (row_inc == {1'b0, n_q} || (WRAP_SPRITES == 0 && clip)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                    lw_load = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Port drive: address held steady across each read wait and its write cycle.
    always_comb begin
        vram_addr_out  = '0;
        vram_wdata_out = '0;
        case (state_q)
            ST_CLS: vram_addr_out = vram_addr(cls_cnt_q[7:3], cls_cnt_q[2:0]);
            ST_RD_A: vram_addr_out = vram_addr(vrow, xb_a);
            ST_WR_A: begin
                vram_addr_out  = vram_addr(vrow, xb_a);
                vram_wdata_out = rdata_q ^ mask_q[7:0];
            end
            ST_RD_B: vram_addr_out = vram_addr(vrow, xb_b);
            ST_WR_B: begin
                vram_addr_out  = vram_addr(vrow, xb_b);
                vram_wdata_out = rdata_q ^ mask_q[15:8];
            end
            default: ;
        endcase
    end

    assign spr_addr_out  = i_q + 12'(row_q);
    assign vram_we_out   = (state_q == ST_WR_A) || (state_q == ST_WR_B) || (state_q == ST_CLS);
    assign busy_out      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_out      = (state_q == ST_DONE);
    assign collision_out = coll_q;

endmodule

// File: doc/chip8_sprite_blitter.md
Name: chip8_sprite_blitter

Overview:
- Executes CHIP-8 DXYN (sprite draw) and 00E0 (clear screen) against the 64x32 monochrome VRAM.
- Sits directly upstream of video_multiplexer and owns the VRAM write port. The HDMI path reads the same RAM through its second port.
- Fetches sprite bytes from main memory, then read-modify-writes VRAM bytes with XOR.
- Reports busy, done and collision (VF) back to the CPU core.

Parameters:
- READ_LATENCY, 2, cycles from address presented to data valid on both the sprite-memory and VRAM read ports.
- WRAP_SPRITES, 0, 0 clips sprites at the right and bottom edges; 1 wraps them modulo 64/32.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-low
- draw_start_in  input  1  one-cycle pulse that starts a DXYN draw
- cls_start_in  input  1  one-cycle pulse that starts a screen clear
- x_in  input  7  Vx; taken modulo 64
- y_in  input  6  Vy; taken modulo 32
- n_in  input  4  sprite height in rows
- i_in  input  12  sprite base address (I register)
- spr_addr_out  output  12  sprite memory read address
- spr_data_in  input  8  sprite byte; bit 7 is the leftmost pixel
- vram_addr_out  output  16  VRAM address {8'b0, y[4:0], xbyte[2:0]}
- vram_wdata_out  output  8  VRAM write data; bit k is pixel x = 8*xbyte + k
- vram_we_out  output  1  VRAM write enable
- vram_rdata_in  input  8  VRAM read data
- busy_out  output  1  high while an operation is in progress
- done_out  output  1  one-cycle pulse when an operation completes
- collision_out  output  1  VF result; held until the next start

Behaviour:
- Reset: every output is 0 and the FSM returns to IDLE. Reset mid-operation abandons the operation with no further writes. A partially drawn sprite remains in VRAM.
- Start acceptance:
  - Starts are accepted only in IDLE. Starts while busy are ignored.
  - If draw_start_in and cls_start_in arrive in the same cycle, the clear wins.
  - On accept: latch the inputs, clear collision_out, and raise busy_out on the next cycle.
- FSM states: IDLE, CLS, FETCH, RD_A, WR_A, RD_B, WR_B, NEXT, DONE.
- CLS:
  - Write 0x00 to addresses 0..255, one per cycle, for 256 cycles.
  - Then DONE. collision_out stays 0.
- Draw, per row r = 0..n-1:
  - FETCH: drive spr_addr_out = i + r (mod 4096) and wait READ_LATENCY cycles. Capture the byte, bit-reverse it, zero-extend it to 16 bits and shift left by x[2:0] to form mask.
  - Byte A: column xb = x[5:3], mask[7:0].
  - Byte B: column xb+1, mask[15:8].
  - RD_A: present the A address and wait READ_LATENCY cycles.
  - WR_A, one cycle: write rdata ^ mask[7:0]; collision |= |(rdata & mask[7:0]).
  - RD_B / WR_B: same as RD_A / WR_A, for byte B.
  - Any byte whose mask is 0 is skipped entirely, with no read and no write.
  - NEXT: r+1; return to FETCH or go to DONE.
- Edge handling:
  - x[2:0] = 0: byte B is always empty.
  - xb = 7 with a nonzero B mask: WRAP_SPRITES=0 skips byte B; WRAP_SPRITES=1 targets column 0 of the same row.
  - y + r >= 32: WRAP_SPRITES=0 ends the draw (go to DONE); WRAP_SPRITES=1 uses row (y + r) mod 32.
  - n = 0: go straight to DONE with collision 0. Sixteen-by-sixteen SCHIP sprites are not supported.
- DONE: pulse done_out for one cycle, drop busy_out, and present the final collision on collision_out in that same cycle.
- Port rules:
  - vram_we_out is high only in WR_A, WR_B and CLS. vram_addr_out must be stable during the write cycle.
  - No VRAM read may be issued before the preceding write to the same byte has completed, so there is no read-after-write hazard.
- Tearing against the display read port is accepted; there is no vblank gating.

Decomposition:
- chip8_pkg:
  - Screen constants SCREEN_W=64, SCREEN_H=32, BYTES_PER_ROW=8, VRAM_BYTES=256.
  - The blitter state enum.
  - A function vram_addr(y, xbyte) returning the 16-bit address. video_multiplexer shares this function.
- One sub-module, latency_wait: a counter that loads READ_LATENCY and flags expiry. It is instanced once and shared by the sprite and VRAM reads.

Test Plan:
- VRAM all 0; draw x=0, y=0, n=1, sprite byte 0xF0 -> one write: addr 0, data 0x0F; collision 0; done pulses once.
- Repeat the same draw -> addr 0 written 0x00; collision 1.
- Cleared VRAM; x=4, y=0, byte 0xFF -> addr 0 = 0xF0, addr 1 = 0x0F, in that order; collision 0.
- WRAP_SPRITES=0: x=60, y=31, n=3, bytes 0xFF -> only addr 255 written (0xF0); no other writes; done. WRAP_SPRITES=1 with the same inputs -> addr 255 = 0xF0, addr 248 = 0x0F, then rows 0 and 1 get the same bytes at addrs 7/0 and 15/8.
- x_in=70, y_in=33, byte 0x80 -> treated as (6,1): addr 8 = 0x40.
- Stimulus: cls pulse arriving in the same cycle as draw_start. Response: the clear runs, writing 0x00 to addrs 0..255 with nothing after. Then in a second run, assert rst_in low mid-clear: vram_we_out falls immediately, busy_out=0, and no further writes occur.
